// File: rtl/muldiv_unit_if.sv
// -----------------------------------------------------------------------------
// muldiv_unit_if
//
// Request/response bundle between the execute stage and muldiv_unit.
//
//   in_valid / in_ready   : request handshake (issuer -> unit)
//   op                    : RV32M funct3 encoding
//   rs1 / rs2             : operands (dividend / divisor for divides)
//   tag_in                : destination tag carried with the request
//   out_valid / out_ready : result handshake (unit -> consumer)
//   rd                    : result
//   tag_out               : tag that travelled with the result
//
// master = issuing/consuming side, slave = the unit itself.
// -----------------------------------------------------------------------------
interface muldiv_unit_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs1;
    logic [WIDTH-1:0] rs2;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] rd;
    logic [TAG_W-1:0] tag_out;

    modport master (
        output in_valid, op, rs1, rs2, tag_in, out_ready,
        input  in_ready, out_valid, rd, tag_out
    );

    modport slave (
        input  in_valid, op, rs1, rs2, tag_in, out_ready,
        output in_ready, out_valid, rd, tag_out
    );
endinterface

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Iterative RV32M multiply/divide unit, one radix-2 step per cycle.
// Multiplication is shift-add on a 2*WIDTH accumulator, division is
// restoring division. Operands are converted to magnitudes on acceptance and
// the recorded result sign is applied in a single fix-up cycle at the end.
// Divide-by-zero and signed overflow bypass the iteration entirely.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   flush  : synchronous abort of anything in flight (highest priority)
//   bus    : muldiv_unit_if.slave request/response bundle
//
// Parameters:
//   WIDTH  : operand/result width, even and >= 8
//   TAG_W  : width of the pass-through tag
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    muldiv_unit_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [2:0]         op_q,    op_d;
    logic [TAG_W-1:0]   tag_q,   tag_d;
    logic               neg_q,   neg_d;
    // Multiplicand magnitude for multiplies, divisor magnitude for divides.
    logic [WIDTH-1:0]   opb_q,   opb_d;
    // Multiply: {partial product high, remaining multiplier / product low}.
    // Divide:   {partial remainder, remaining dividend / quotient bits}.
    logic [2*WIDTH-1:0] acc_q,   acc_d;
    logic [WIDTH-1:0]   rd_q,    rd_d;

    // ------------------------------------------------------------------
    // Operand decode at acceptance
    // ------------------------------------------------------------------
    logic             a_signed, b_signed;
    logic             sign_a, sign_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             in_is_div, in_is_rem;
    logic             div_zero, div_ovf;
    logic [WIDTH-1:0] special_res;

    always_comb begin
        a_signed  = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                    (bus.op == OP_DIV)  || (bus.op == OP_REM);
        b_signed  = (bus.op == OP_MULH) || (bus.op == OP_DIV) ||
                    (bus.op == OP_REM);
        sign_a    = a_signed & bus.rs1[WIDTH-1];
        sign_b    = b_signed & bus.rs2[WIDTH-1];
        mag_a     = sign_a ? ({WIDTH{1'b0}} - bus.rs1) : bus.rs1;
        mag_b     = sign_b ? ({WIDTH{1'b0}} - bus.rs2) : bus.rs2;
        in_is_div = bus.op[2];
        in_is_rem = bus.op[2] & bus.op[1];
        div_zero  = in_is_div && (bus.rs2 == {WIDTH{1'b0}});
        div_ovf   = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                    (bus.rs1 == MOST_NEG) && (bus.rs2 == ALL_ONES);
        // Overflow is only checked when the divisor is non-zero, so the
        // zero case takes precedence here.
        if (div_zero)
            special_res = in_is_rem ? bus.rs1 : ALL_ONES;
        else
            special_res = in_is_rem ? {WIDTH{1'b0}} : bus.rs1;
    end

    // ------------------------------------------------------------------
    // One radix-2 step of each algorithm
    // ------------------------------------------------------------------
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        // Add the multiplicand into the high half when the current
        // multiplier bit is set; the carry is kept by shifting right.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
        mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                            : {1'b0, acc_q[2*WIDTH-1:1]};

        // Bring the next dividend bit into the partial remainder and try to
        // subtract. The partial remainder is always below the divisor, so
        // the shifted value fits in WIDTH+1 bits and the restored or
        // reduced remainder fits back into WIDTH bits.
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        if (div_diff[WIDTH])
            div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        else
            div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end

    // ------------------------------------------------------------------
    // Sign fix-up and result selection
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [WIDTH-1:0]   fix_res;

    always_comb begin
        prod_fix = neg_q ? ({(2*WIDTH){1'b0}} - acc_q) : acc_q;
        quo_fix  = neg_q ? ({WIDTH{1'b0}} - acc_q[WIDTH-1:0])
                         : acc_q[WIDTH-1:0];
        rem_fix  = neg_q ? ({WIDTH{1'b0}} - acc_q[2*WIDTH-1:WIDTH])
                         : acc_q[2*WIDTH-1:WIDTH];
        case (op_q)
            OP_MUL:                   fix_res = prod_fix[WIDTH-1:0];
            OP_MULH, OP_MULHSU,
            OP_MULHU:                 fix_res = prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:          fix_res = quo_fix;
            default:                  fix_res = rem_fix;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        tag_d   = tag_q;
        neg_d   = neg_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        rd_d    = rd_q;

        if (flush) begin
            // Abort wins over acceptance and retirement on the same edge.
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        op_d  = bus.op;
                        tag_d = bus.tag_in;
                        // Remainder takes the dividend's sign; product and
                        // quotient take the XOR of both signs.
                        neg_d = in_is_rem ? sign_a : (sign_a ^ sign_b);
                        if (div_zero || div_ovf) begin
                            rd_d    = special_res;
                            cnt_d   = '0;
                            state_d = S_DONE;
                        end else begin
                            if (in_is_div) begin
                                acc_d = {{WIDTH{1'b0}}, mag_a};
                                opb_d = mag_b;
                            end else begin
                                acc_d = {{WIDTH{1'b0}}, mag_b};
                                opb_d = mag_a;
                            end
                            cnt_d   = CNT_W'(WIDTH);
                            state_d = S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    acc_d = op_q[2] ? div_next : mul_next;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1))
                        state_d = S_FIX;
                end
                S_FIX: begin
                    rd_d    = fix_res;
                    state_d = S_DONE;
                end
                default: begin
                    if (bus.out_ready)
                        state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            tag_q   <= '0;
            neg_q   <= 1'b0;
            opb_q   <= '0;
            acc_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            tag_q   <= tag_d;
            neg_q   <= neg_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            rd_q    <= rd_d;
        end
    end

    // All outputs come straight from registers.
    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.rd        = rd_q;
    assign bus.tag_out   = tag_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//
// Drives a WIDTH=32 and a WIDTH=8 instance of muldiv_unit. Directed vectors,
// backpressure/flush/reset sequences on the 32-bit unit, and a random sweep
// on both widths against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush32 = 1'b0;
    logic flush8 = 1'b0;

    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(32), .TAG_W(5)) i32 ();
    muldiv_unit_if #(.WIDTH(8),  .TAG_W(5)) i8  ();

    muldiv_unit #(.WIDTH(32), .TAG_W(5)) u32 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush32),
        .bus   (i32.slave)
    );

    muldiv_unit #(.WIDTH(8), .TAG_W(5)) u8 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush8),
        .bus   (i8.slave)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic on 64-bit integers.
    function automatic logic [31:0] model(input int w, input logic [2:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
        longint mask, ua, ub, sa, sb, minv, r;
        mask = (longint'(1) << w) - 1;
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        sa   = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
        sb   = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
        minv = -(longint'(1) << (w - 1));
        case (op)
            3'd0: r = sa * sb;
            3'd1: r = (sa * sb) >>> w;
            3'd2: r = (sa * ub) >>> w;
            3'd3: r = (ua * ub) >> w;
            3'd4: r = (ub == 0) ? -1 : ((sa == minv && sb == -1) ? sa : sa / sb);
            3'd5: r = (ub == 0) ? -1 : ua / ub;
            3'd6: r = (ub == 0) ? sa : ((sa == minv && sb == -1) ? 0 : sa % sb);
            default: r = (ub == 0) ? ua : ua % ub;
        endcase
        return 32'(r & mask);
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [31:0] mask;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return mask;
            3: return 32'd1 << (w - 1);
            4: return 32'($urandom_range(0, 9));
            default: return $urandom & mask;
        endcase
    endfunction

    task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input bit rnd,
                         output logic [31:0] res, output logic [4:0] tg,
                         output int lat, output bit ok);
        int k;
        ok = 1; res = '0; tg = '0;
        i32.op = op; i32.rs1 = a; i32.rs2 = b; i32.tag_in = tag;
        i32.in_valid = 1'b1; i32.out_ready = 1'b1;
        @(posedge clk); #1;
        i32.in_valid = 1'b0;
        lat = 1;
        while (!i32.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!i32.out_valid) begin
            ok = 0;
            return;
        end
        res = i32.rd; tg = i32.tag_out;
        k = 0;
        do begin
            i32.out_ready = !rnd || (k >= 8) || ($urandom_range(0, 2) == 0);
            @(posedge clk); #1;
            if (!i32.out_ready && (!i32.out_valid || i32.rd !== res ||
                                   i32.tag_out !== tg || i32.in_ready))
                ok = 0;
            k++;
        end while (!i32.out_ready);
        if (i32.out_valid || !i32.in_ready) ok = 0;
        $display("w32 op=%0d a=%h b=%h rd=%h tag=%h lat=%0d", op, a, b, res, tg, lat);
    endtask

    task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [4:0] tag,
                        output logic [7:0] res, output logic [4:0] tg,
                        output int lat, output bit ok);
        int k;
        ok = 1; res = '0; tg = '0;
        i8.op = op; i8.rs1 = a; i8.rs2 = b; i8.tag_in = tag;
        i8.in_valid = 1'b1; i8.out_ready = 1'b1;
        @(posedge clk); #1;
        i8.in_valid = 1'b0;
        lat = 1;
        while (!i8.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!i8.out_valid) begin
            ok = 0;
            return;
        end
        res = i8.rd; tg = i8.tag_out;
        k = 0;
        do begin
            i8.out_ready = (k >= 8) || ($urandom_range(0, 2) == 0);
            @(posedge clk); #1;
            if (!i8.out_ready && (!i8.out_valid || i8.rd !== res ||
                                  i8.tag_out !== tg || i8.in_ready))
                ok = 0;
            k++;
        end while (!i8.out_ready);
        if (i8.out_valid || !i8.in_ready) ok = 0;
        $display("w8 op=%0d a=%h b=%h rd=%h tag=%h lat=%0d", op, a, b, res, tg, lat);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [31:0] res, cap_rd;
        logic [7:0]  res8;
        logic [4:0]  tg, cap_tg;
        int          lat;
        bit          ok, seen;

        vecs[0]  = '{3'd0, 32'd7,         32'hFFFF_FFFD, 5'h13, 32'hFFFF_FFEB, 34};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h01, 32'hFFFF_FFFE, 34};
        vecs[2]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'h02, 32'h4000_0000, 34};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,         5'h03, 32'hFFFF_FFFF, 34};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         5'h04, 32'hFFFF_FFFD, 34};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         5'h05, 32'hFFFF_FFFF, 34};
        vecs[6]  = '{3'd5, 32'd100,       32'd7,         5'h13, 32'd14,        34};
        vecs[7]  = '{3'd7, 32'd100,       32'd7,         5'h07, 32'd2,         34};
        vecs[8]  = '{3'd4, 32'h0000_0055, 32'd0,         5'h08, 32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'd7, 32'h0000_1234, 32'd0,         5'h09, 32'h0000_1234, 1};
        vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'h0A, 32'h8000_0000, 1};
        vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'h0B, 32'd0,         1};

        i32.in_valid = 1'b0; i32.op = '0; i32.rs1 = '0; i32.rs2 = '0;
        i32.tag_in = '0; i32.out_ready = 1'b1;
        i8.in_valid = 1'b0; i8.op = '0; i8.rs1 = '0; i8.rs2 = '0;
        i8.tag_in = '0; i8.out_ready = 1'b1;

        // Reset state
        #12;
        check("rst_in_ready", i32.in_ready, 1);
        check("rst_out_valid", i32.out_valid, 0);
        check("rst_rd", i32.rd, 0);
        check("rst_tag", i32.tag_out, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        for (int i = 0; i < 12; i++) begin
            run32(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, 1'b0, res, tg, lat, ok);
            check($sformatf("vec%0d_handshake", i), ok, 1);
            check($sformatf("vec%0d_rd", i), res, vecs[i].exp);
            check($sformatf("vec%0d_tag", i), tg, vecs[i].tag);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
        end

        // Backpressure: result held for 10 cycles
        i32.out_ready = 1'b0;
        i32.op = 3'd5; i32.rs1 = 32'd1000; i32.rs2 = 32'd3; i32.tag_in = 5'h1C;
        i32.in_valid = 1'b1;
        @(posedge clk); #1;
        i32.in_valid = 1'b0;
        lat = 1;
        while (!i32.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_valid", i32.out_valid, 1);
        cap_rd = i32.rd; cap_tg = i32.tag_out;
        check("bp_rd", cap_rd, 32'd333);
        check("bp_tag", cap_tg, 5'h1C);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", i32.out_valid, 1);
            check("bp_hold_rd", i32.rd, cap_rd);
            check("bp_hold_tag", i32.tag_out, cap_tg);
            check("bp_hold_in_ready", i32.in_ready, 0);
        end
        i32.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_retire_valid", i32.out_valid, 0);
        check("bp_retire_in_ready", i32.in_ready, 1);
        $display("w32 backpressure rd=%h tag=%h", cap_rd, cap_tg);

        // Flush on the 5th BUSY cycle
        i32.op = 3'd0; i32.rs1 = 32'd123; i32.rs2 = 32'd456; i32.tag_in = 5'h11;
        i32.in_valid = 1'b1;
        @(posedge clk); #1;
        i32.in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        flush32 = 1'b1;
        @(posedge clk); #1;
        flush32 = 1'b0;
        check("flush_in_ready", i32.in_ready, 1);
        check("flush_out_valid", i32.out_valid, 0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (i32.out_valid) seen = 1;
        end
        check("flush_no_result", seen, 0);
        $display("w32 flush mid-busy");

        run32(3'd0, 32'd3, 32'd5, 5'h0F, 1'b0, res, tg, lat, ok);
        check("post_flush_handshake", ok, 1);
        check("post_flush_rd", res, 32'd15);

        // Request presented together with flush is dropped
        flush32 = 1'b1;
        i32.op = 3'd0; i32.rs1 = 32'd2; i32.rs2 = 32'd2; i32.tag_in = 5'h12;
        i32.in_valid = 1'b1;
        @(posedge clk); #1;
        flush32 = 1'b0; i32.in_valid = 1'b0;
        check("flush_drop_in_ready", i32.in_ready, 1);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (i32.out_valid) seen = 1;
        end
        check("flush_drop_no_result", seen, 0);
        $display("w32 flush with request");

        // Asynchronous reset mid-BUSY
        i32.op = 3'd5; i32.rs1 = 32'd50; i32.rs2 = 32'd7; i32.tag_in = 5'h09;
        i32.in_valid = 1'b1;
        @(posedge clk); #1;
        i32.in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("pre_rst_in_ready", i32.in_ready, 0);
        rst_n = 1'b0;
        #1;
        check("async_rst_in_ready", i32.in_ready, 1);
        check("async_rst_out_valid", i32.out_valid, 0);
        check("async_rst_rd", i32.rd, 0);
        check("async_rst_tag", i32.tag_out, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("w32 reset mid-busy");

        // Random sweep, WIDTH=32
        for (int n = 0; n < 150; n++) begin
            logic [2:0]  rop;
            logic [31:0] ra, rb;
            logic [4:0]  rt;
            rop = 3'($urandom_range(0, 7));
            ra = pick(32); rb = pick(32);
            rt = 5'($urandom);
            run32(rop, ra, rb, rt, 1'b1, res, tg, lat, ok);
            check("rnd32_handshake", ok, 1);
            check("rnd32_rd", res, model(32, rop, ra, rb));
            check("rnd32_tag", tg, rt);
        end

        // Random sweep, WIDTH=8
        for (int n = 0; n < 200; n++) begin
            logic [2:0]  rop;
            logic [31:0] ra, rb;
            logic [4:0]  rt;
            logic [31:0] exp8;
            rop = 3'($urandom_range(0, 7));
            ra = pick(8); rb = pick(8);
            rt = 5'($urandom);
            run8(rop, ra[7:0], rb[7:0], rt, res8, tg, lat, ok);
            exp8 = model(8, rop, ra, rb);
            check("rnd8_handshake", ok, 1);
            check("rnd8_rd", res8, exp8[7:0]);
            check("rnd8_tag", tg, rt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
